// File: rtl/cpu_pkg.sv
// Shared CPU types: forwarding-select encodings and the shadow pipeline stage record.
package cpu_pkg;

   localparam logic [1:0] FWD_REGFILE  = 2'd0;
   localparam logic [1:0] FWD_EXE_ALU  = 2'd1;
   localparam logic [1:0] FWD_MEM_ALU  = 2'd2;
   localparam logic [1:0] FWD_MEM_LOAD = 2'd3;

   // Register-number field is sized for the widest supported register file (REG_AW <= RN_W).
   localparam int unsigned RN_W = 8;

   typedef struct packed {
      logic            valid;
      logic            wreg;
      logic            m2reg;
      logic [RN_W-1:0] rn;
   } stage_t;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// ID-stage request and hazard-control response bundle between the CPU datapath and the hazard unit.
interface pipeline_hazard_unit_if #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned CNT_W   = 16
);
   logic                      id_valid;
   logic [NUM_SRC*REG_AW-1:0] id_rs;
   logic [NUM_SRC-1:0]        id_rs_used;
   logic                      id_wreg;
   logic                      id_m2reg;
   logic [REG_AW-1:0]         id_rn;
   logic                      id_branch_taken;

   logic [2*NUM_SRC-1:0]      fwd_sel;
   logic                      stall;
   logic                      bubble;
   logic                      flush_ifid;
   logic [CNT_W-1:0]          stall_cnt;
   logic [CNT_W-1:0]          flush_cnt;

   modport master (
      output id_valid, id_rs, id_rs_used, id_wreg, id_m2reg, id_rn, id_branch_taken,
      input  fwd_sel, stall, bubble, flush_ifid, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rs_used, id_wreg, id_m2reg, id_rn, id_branch_taken,
      output fwd_sel, stall, bubble, flush_ifid, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_cmp.sv
// Per-operand hazard comparator: load-use detection and priority-encoded forwarding select.
module hazard_cmp
   import cpu_pkg::*;
#(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LOAD_LAT = 1
) (
   input  logic [REG_AW-1:0] rs_i,
   input  logic              rs_used_i,
   input  stage_t            s_exe_i,
   input  stage_t            s_mem_i,
   input  stage_t            s_mem2_i,
   output logic [1:0]        sel_o,
   output logic              load_hz_o
);

   logic [RN_W-1:0] rs_ext;
   logic            hit_exe;
   logic            hit_mem;
   logic            hit_mem2;

   function automatic logic hit(input stage_t s, input logic [RN_W-1:0] rs, input logic used);
      return used && s.valid && s.wreg && (s.rn == rs) && (rs != '0);
   endfunction

   assign rs_ext   = RN_W'(rs_i);
   assign hit_exe  = hit(s_exe_i, rs_ext, rs_used_i);
   assign hit_mem  = hit(s_mem_i, rs_ext, rs_used_i);
   assign hit_mem2 = hit(s_mem2_i, rs_ext, rs_used_i);

   always_comb begin
      load_hz_o = hit_exe && s_exe_i.m2reg;
      if (LOAD_LAT == 2) begin
         load_hz_o = load_hz_o || (hit_mem && s_mem_i.m2reg);
      end

      sel_o = FWD_REGFILE;
      if (hit_exe && !s_exe_i.m2reg) begin
         sel_o = FWD_EXE_ALU;
      end else if (hit_mem && !s_mem_i.m2reg) begin
         sel_o = FWD_MEM_ALU;
      end else if (LOAD_LAT == 1 && hit_mem && s_mem_i.m2reg) begin
         sel_o = FWD_MEM_LOAD;
      end else if (LOAD_LAT == 2 && hit_mem2 && s_mem2_i.m2reg) begin
         sel_o = FWD_MEM_LOAD;
      end
   end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller: shadow pipeline of destination info, load-use stall,
// ID/EXE bubble, IF/ID flush on taken branches and saturating event counters.
module pipeline_hazard_unit
   import cpu_pkg::*;
#(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 16
) (
   input logic                  clk_i,
   input logic                  rst_i,
   pipeline_hazard_unit_if.slave hz_if
);

   stage_t               id_stage;
   stage_t               s_exe_d, s_exe_q;
   stage_t               s_mem_q;
   // With LOAD_LAT=1 this stage is the WB shadow, which is never forwarded from.
   stage_t               s_mem2_q;
   logic [NUM_SRC-1:0]   load_hz;
   logic [2*NUM_SRC-1:0] sel_raw;
   logic                 stall;
   logic                 flush;
   logic [CNT_W-1:0]     stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0]     flush_cnt_d, flush_cnt_q;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_cmp
      hazard_cmp #(
         .REG_AW   (REG_AW),
         .LOAD_LAT (LOAD_LAT)
      ) u_hazard_cmp (
         .rs_i      (hz_if.id_rs[k*REG_AW +: REG_AW]),
         .rs_used_i (hz_if.id_rs_used[k]),
         .s_exe_i   (s_exe_q),
         .s_mem_i   (s_mem_q),
         .s_mem2_i  (s_mem2_q),
         .sel_o     (sel_raw[2*k +: 2]),
         .load_hz_o (load_hz[k])
      );
   end

   always_comb begin
      id_stage       = '0;
      id_stage.valid = hz_if.id_valid;
      id_stage.wreg  = hz_if.id_wreg;
      id_stage.m2reg = hz_if.id_m2reg;
      id_stage.rn    = RN_W'(hz_if.id_rn);

      stall = hz_if.id_valid && (|load_hz);
      // A stalled branch has stale operands; it is re-evaluated next cycle instead of flushing.
      flush = hz_if.id_valid && hz_if.id_branch_taken && !stall;

      s_exe_d = (hz_if.id_valid && !stall) ? id_stage : '0;

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      flush_cnt_d = flush_cnt_q;
      if (flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s_exe_q     <= '0;
         s_mem_q     <= '0;
         s_mem2_q    <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         s_exe_q     <= s_exe_d;
         s_mem_q     <= s_exe_q;
         s_mem2_q    <= s_mem_q;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz_if.fwd_sel    = stall ? '0 : sel_raw;
   assign hz_if.stall      = stall;
   assign hz_if.bubble     = stall;
   assign hz_if.flush_ifid = flush;
   assign hz_if.stall_cnt  = stall_cnt_q;
   assign hz_if.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench: LOAD_LAT=1 and LOAD_LAT=2 (2-bit counters) instances driven from vector tables.
module tb_pipeline_hazard_unit;

   typedef struct {
      logic       rst;
      logic       valid;
      logic [4:0] rs0;
      logic [4:0] rs1;
      logic [1:0] used;
      logic       wreg;
      logic       m2;
      logic [4:0] rn;
      logic       br;
      logic [3:0] sel;
      logic       stall;
      logic       flush;
      int         scnt;
      int         fcnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst1;
   logic rst2;
   int   n_checks = 0;
   int   n_errors = 0;
   vec_t exp_q[$];
   vec_t seq1[$];
   vec_t seq2[$];

   always #5 clk = ~clk;

   pipeline_hazard_unit_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) if1 ();
   pipeline_hazard_unit_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(2))  if2 ();

   pipeline_hazard_unit #(
      .REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)
   ) u_dut1 (
      .clk_i (clk),
      .rst_i (rst1),
      .hz_if (if1)
   );

   pipeline_hazard_unit #(
      .REG_AW(5), .NUM_SRC(2), .LOAD_LAT(2), .CNT_W(2)
   ) u_dut2 (
      .clk_i (clk),
      .rst_i (rst2),
      .hz_if (if2)
   );

   function automatic vec_t mk(input logic rst, input logic valid, input logic [4:0] rs0,
                               input logic [4:0] rs1, input logic [1:0] used, input logic wreg,
                               input logic m2, input logic [4:0] rn, input logic br,
                               input logic [3:0] sel, input logic stall, input logic flush,
                               input int scnt, input int fcnt);
      vec_t v;
      v.rst = rst; v.valid = valid; v.rs0 = rs0; v.rs1 = rs1; v.used = used;
      v.wreg = wreg; v.m2 = m2; v.rn = rn; v.br = br;
      v.sel = sel; v.stall = stall; v.flush = flush; v.scnt = scnt; v.fcnt = fcnt;
      return v;
   endfunction

   task automatic drive(input int which, input vec_t v);
      if (which == 0) begin
         rst1 = v.rst;
         if1.id_valid = v.valid; if1.id_rs = {v.rs1, v.rs0}; if1.id_rs_used = v.used;
         if1.id_wreg = v.wreg; if1.id_m2reg = v.m2; if1.id_rn = v.rn;
         if1.id_branch_taken = v.br;
      end else begin
         rst2 = v.rst;
         if2.id_valid = v.valid; if2.id_rs = {v.rs1, v.rs0}; if2.id_rs_used = v.used;
         if2.id_wreg = v.wreg; if2.id_m2reg = v.m2; if2.id_rn = v.rn;
         if2.id_branch_taken = v.br;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic sample(input int which, input int idx);
      vec_t  e;
      string p;
      p = $sformatf("dut%0d[%0d]", which + 1, idx);
      if (exp_q.size() == 0) begin
         chk({p, " scoreboard_empty"}, 0, 1);
         return;
      end
      e = exp_q.pop_front();
      if (which == 0) begin
         chk({p, " fwd_sel"},    int'(if1.fwd_sel),    int'(e.sel));
         chk({p, " stall"},      int'(if1.stall),      int'(e.stall));
         chk({p, " bubble"},     int'(if1.bubble),     int'(e.stall));
         chk({p, " flush_ifid"}, int'(if1.flush_ifid), int'(e.flush));
         chk({p, " stall_cnt"},  int'(if1.stall_cnt),  e.scnt);
         chk({p, " flush_cnt"},  int'(if1.flush_cnt),  e.fcnt);
      end else begin
         chk({p, " fwd_sel"},    int'(if2.fwd_sel),    int'(e.sel));
         chk({p, " stall"},      int'(if2.stall),      int'(e.stall));
         chk({p, " bubble"},     int'(if2.bubble),     int'(e.stall));
         chk({p, " flush_ifid"}, int'(if2.flush_ifid), int'(e.flush));
         chk({p, " stall_cnt"},  int'(if2.stall_cnt),  e.scnt);
         chk({p, " flush_cnt"},  int'(if2.flush_cnt),  e.fcnt);
      end
   endtask

   task automatic run(input int which, input vec_t seq[$]);
      foreach (seq[i]) begin
         @(posedge clk);
         #1;
         drive(which, seq[i]);
         exp_q.push_back(seq[i]);
         @(negedge clk);
         sample(which, i);
      end
   endtask

   initial begin
      vec_t idle;
      idle = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
      drive(0, idle);
      drive(1, idle);

      // LOAD_LAT=1:  rst valid rs0 rs1 used wreg m2 rn br | sel stall flush scnt fcnt
      seq1.push_back(mk(0, 1,  1,  2, 2'b11, 1, 0,  3, 0, 4'b0000, 0, 0, 0, 0)); // reset state
      seq1.push_back(mk(0, 1,  3,  4, 2'b11, 1, 0,  6, 0, 4'b0001, 0, 0, 0, 0)); // r3 from EXE
      seq1.push_back(mk(0, 1,  7,  8, 2'b11, 1, 0,  9, 0, 4'b0000, 0, 0, 0, 0)); // unrelated
      seq1.push_back(mk(0, 1, 10,  6, 2'b11, 1, 0, 11, 0, 4'b1000, 0, 0, 0, 0)); // r6 from MEM
      seq1.push_back(mk(0, 1,  1,  0, 2'b01, 1, 1,  5, 0, 4'b0000, 0, 0, 0, 0)); // lw r5
      seq1.push_back(mk(0, 1,  5, 11, 2'b11, 1, 0, 12, 0, 4'b0000, 1, 0, 0, 0)); // load-use stall
      seq1.push_back(mk(0, 1,  5, 11, 2'b11, 1, 0, 12, 0, 4'b0011, 0, 0, 1, 0)); // r5 load data
      seq1.push_back(mk(0, 1, 12,  0, 2'b11, 0, 0,  0, 1, 4'b0001, 0, 1, 1, 0)); // taken beq
      seq1.push_back(mk(0, 1, 12,  0, 2'b01, 1, 1,  7, 0, 4'b0010, 0, 0, 1, 1)); // lw r7
      seq1.push_back(mk(0, 1,  7,  1, 2'b11, 0, 0,  0, 1, 4'b0000, 1, 0, 1, 1)); // beq stalls
      seq1.push_back(mk(0, 1,  7,  1, 2'b11, 0, 0,  0, 1, 4'b0011, 0, 1, 2, 1)); // beq flushes
      seq1.push_back(mk(0, 1,  1,  0, 2'b01, 1, 1,  0, 0, 4'b0000, 0, 0, 2, 2)); // lw r0
      seq1.push_back(mk(0, 1,  0,  0, 2'b11, 1, 0,  4, 0, 4'b0000, 0, 0, 2, 2)); // read r0
      seq1.push_back(mk(0, 1,  1,  0, 2'b01, 1, 1,  9, 0, 4'b0000, 0, 0, 2, 2)); // lw r9
      seq1.push_back(mk(0, 0,  9,  0, 2'b01, 1, 0, 13, 0, 4'b0000, 0, 0, 2, 2)); // invalid ID
      seq1.push_back(mk(0, 1,  9,  4, 2'b11, 1, 0, 14, 0, 4'b0011, 0, 0, 2, 2)); // r9 load, r4 WB
      seq1.push_back(mk(0, 1, 14, 14, 2'b00, 0, 0,  0, 0, 4'b0000, 0, 0, 2, 2)); // unused ops
      seq1.push_back(mk(0, 1,  1,  0, 2'b01, 1, 1,  5, 0, 4'b0000, 0, 0, 2, 2)); // lw r5
      seq1.push_back(mk(1, 1,  5,  0, 2'b01, 1, 0,  6, 0, 4'b0000, 1, 0, 2, 2)); // stall, rst up
      seq1.push_back(mk(0, 1,  5,  0, 2'b01, 1, 0,  6, 0, 4'b0000, 0, 0, 0, 0)); // after reset

      // LOAD_LAT=2 with 2-bit counters
      seq2.push_back(mk(0, 1,  1,  0, 2'b01, 1, 1,  5, 0, 4'b0000, 0, 0, 0, 0)); // lw r5
      seq2.push_back(mk(0, 1,  5,  0, 2'b01, 1, 0,  6, 0, 4'b0000, 1, 0, 0, 0)); // stall 1
      seq2.push_back(mk(0, 1,  5,  0, 2'b01, 1, 0,  6, 0, 4'b0000, 1, 0, 1, 0)); // stall 2
      seq2.push_back(mk(0, 1,  5,  0, 2'b01, 1, 0,  6, 0, 4'b0011, 0, 0, 2, 0)); // from MEM2 load
      seq2.push_back(mk(0, 1,  1,  0, 2'b01, 1, 1,  8, 0, 4'b0000, 0, 0, 2, 0)); // lw r8
      seq2.push_back(mk(0, 1,  0,  8, 2'b10, 1, 0,  9, 0, 4'b0000, 1, 0, 2, 0)); // op1 stall
      seq2.push_back(mk(0, 1,  0,  8, 2'b10, 1, 0,  9, 0, 4'b0000, 1, 0, 3, 0)); // stall, cnt max
      seq2.push_back(mk(0, 1,  0,  8, 2'b10, 1, 0,  9, 0, 4'b1100, 0, 0, 3, 0)); // saturated
      seq2.push_back(mk(0, 1,  0,  0, 2'b00, 0, 0,  0, 1, 4'b0000, 0, 1, 3, 0)); // taken branch
      seq2.push_back(mk(0, 0,  0,  0, 2'b00, 0, 0,  0, 0, 4'b0000, 0, 0, 3, 1)); // idle
      seq2.push_back(mk(0, 1,  9,  0, 2'b01, 0, 0,  0, 0, 4'b0000, 0, 0, 3, 1)); // MEM2 ALU: no fwd

      repeat (2) @(posedge clk);
      run(0, seq1);
      run(1, seq2);
      if (exp_q.size() != 0) begin
         chk("scoreboard_drained", exp_q.size(), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Centralised hazard and forwarding controller for the 5-stage pipelined CPU (IF/ID/EXE/MEM/WB).
- Keeps its own shadow pipeline of destination-register information for the EXE, MEM and WB stages.
- From that, generates per-operand forwarding selects, load-use stalls, ID/EXE bubble insertion and IF/ID flush on taken branches.
- Parametrised in source-operand count and load latency; provides saturating performance counters.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands checked per ID instruction.
- LOAD_LAT, 1, memory-read latency in stages beyond EXE (legal: 1 or 2).
- CNT_W, 16, width of the stall and flush counters.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  NUM_SRC*REG_AW  source register numbers, operand k at bits [k*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  operand k is actually read.
- id_wreg  in  1  ID instruction writes the register file.
- id_m2reg  in  1  ID instruction is a load.
- id_rn  in  REG_AW  ID destination register.
- id_branch_taken  in  1  ID resolved a taken branch or jump (pcsource != 0).
- fwd_sel  out  2*NUM_SRC  per-operand select: 0 = regfile, 1 = EXE ALU, 2 = MEM ALU, 3 = MEM load data.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load NOP into ID/EXE this edge.
- flush_ifid  out  1  clear IF/ID this edge.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of flushes.

Behaviour:
- Shadow stages S_EXE, S_MEM, S_WB (plus S_MEM2 when LOAD_LAT = 2). Each holds {valid, wreg, m2reg, rn}.
- Each rising edge:
  - S_WB <= S_MEM (or S_MEM2 when LOAD_LAT = 2), S_MEM <= S_EXE.
  - S_EXE <= ID info if id_valid && !bubble; otherwise S_EXE is cleared (invalid).
- Hazard match, operand k against stage X: id_rs_used[k] && X.valid && X.wreg && X.rn == id_rs[k] && id_rs[k] != 0.
- Load-use stall is combinational, asserted when id_valid and any operand matches:
  - S_EXE with m2reg; or
  - when LOAD_LAT = 2, S_MEM with m2reg.
- bubble = stall.
- fwd_sel[k], first match wins:
  - S_EXE non-load -> 1.
  - S_MEM non-load -> 2.
  - S_MEM load (LOAD_LAT = 1) or S_MEM2 load (LOAD_LAT = 2) -> 3.
  - else 0.
  - WB is never forwarded; the register file is write-before-read.
- fwd_sel is forced to 0 while stall = 1.
- flush_ifid = id_valid && id_branch_taken && !stall. The stall wins because branch operands are stale; the branch is re-evaluated next cycle.
- Counters:
  - stall_cnt increments on each cycle with stall = 1.
  - flush_cnt increments on each cycle with flush_ifid = 1.
  - Both saturate at all-ones with no wrap.
- Reset (sync, high): all shadow stages invalid and both counters 0. Therefore stall, bubble, flush_ifid and fwd_sel are all 0 in the cycle after reset. Reset mid-stall drops the stall on the next edge.
- id_rs or id_rn equal to 0 never produces a hazard.
- Latency:
  - Outputs are combinational from ID inputs and the shadow registers; they are valid in the same cycle.
  - Shadow state updates one edge later.

Decomposition:
- Shared package cpu_pkg holds:
  - FWD_REGFILE, FWD_EXE_ALU, FWD_MEM_ALU, FWD_MEM_LOAD (2-bit constants).
  - The shadow-stage struct type {valid, wreg, m2reg, rn}.
- One natural sub-module: hazard_cmp. It is a combinational per-operand comparator and priority encoder, instantiated NUM_SRC times via generate.

Test Plan:
- add r3 in EXE, next instruction reads r3 as operand 0 -> fwd_sel[1:0] = 1, stall = 0.
- add r3 then an unrelated instruction, then a reader of r3 -> fwd_sel = 2 in the reader's ID cycle.
- lw r5 followed immediately by a reader of r5 (LOAD_LAT = 1):
  - Cycle 1: stall = 1, bubble = 1, stall_cnt = 1.
  - Cycle 2: stall = 0, fwd_sel = 3.
- Same lw-then-read sequence with LOAD_LAT = 2 -> stall for exactly 2 cycles, then fwd_sel = 3, stall_cnt = 2.
- Taken beq in ID with no hazard -> flush_ifid = 1 for 1 cycle, flush_cnt = 1. Taken beq whose operand depends on a load in EXE -> stall = 1, flush_ifid = 0, then flush_ifid = 1 in the following cycle.
- Write to r0 followed by a reader of r0 -> fwd_sel = 0, stall = 0. Assert Reset during a stall -> stall = 0 after the edge and counters = 0.
